muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning operand/result width in bits.
REQ-002 SHALL provide parameter CNTW, default 6, meaning iteration counter width; must hold XLEN.
REQ-003 SHALL provide port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL provide port start  input  1  meaning request a new operation; sampled only when not busy.
REQ-006 SHALL provide port op  input  2  meaning 2'b00 mul (low XLEN bits), 2'b01 divu, 2'b10 remu, 2'b11 reserved.
REQ-007 SHALL provide port a  input  XLEN  meaning multiplicand/dividend, captured at start.
REQ-008 SHALL provide port b  input  XLEN  meaning multiplier/divisor, captured at start.
REQ-009 SHALL provide port busy  output  1  meaning an operation is iterating.
REQ-010 SHALL provide port done  output  1  meaning one-cycle pulse: result is valid.
REQ-011 SHALL provide port result  output  XLEN  meaning registered result, held until the next accepted start.

Function
REQ-012 SHALL implement an FSM with states IDLE, MUL, DIV, DONE; busy = (state==MUL or state==DIV); done = (state==DONE).
REQ-013 SHALL accept start in IDLE or DONE; on acceptance capture a, b, op, and clear the counter to 0.
REQ-014 SHALL ignore start, a, b, op while busy; captured operands must not change.
REQ-015 SHALL transition on accepted op 2'b00 to MUL; op 2'b01/2'b10 with b!=0 to DIV; op 2'b01/2'b10 with b==0 directly to DONE.
REQ-016 SHALL, in MUL, perform one shift-add step per cycle (radix-2, XLEN steps), keeping only the low XLEN product bits.
REQ-017 SHALL, in DIV, perform one restoring-division step per cycle (XLEN steps), unsigned, keeping quotient and remainder.
REQ-018 SHALL, on the edge completing step XLEN, load result and enter DONE; done therefore rises XLEN+1 cycles after the accepting edge (33 for XLEN=32).
REQ-019 SHALL, for divide by zero, load result = all ones (divu) or a (remu) and assert done one cycle after the accepting edge.
REQ-020 SHALL remain in DONE exactly one cycle, then go to IDLE unless a new start is accepted (back-to-back, no bubble).
REQ-021 SHALL treat op 2'b11 as mul.
REQ-022 SHALL not modify result in any state other than the completion edge or reset.

Reset
REQ-023 SHALL, while reset is low, force state IDLE, busy 0, done 0, result 0, counter 0, internal operand registers 0, regardless of clk.
REQ-024 SHALL abort any in-flight operation on reset assertion with no done pulse; first start is accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-025 SHALL compile remainder support only when macro MULDIV_REM_EN is defined: with it, op 2'b10 returns the remainder per REQ-017/REQ-019.
REQ-026 SHALL, without MULDIV_REM_EN, treat op 2'b10 identically to divu (quotient), omitting remainder output muxing; iteration latency is unchanged.

Verification
REQ-027 SHALL verify: op=00, a=7, b=6, start 1 cycle -> busy 1 for 32 cycles, done pulse 33 cycles after start, result=42.
REQ-028 SHALL verify: op=00, a=32'hFFFFFFFF, b=2 -> result=32'hFFFFFFFE; then immediate start in DONE cycle with op=01, a=100, b=7 -> next done with result=14.
REQ-029 SHALL verify: op=10, a=100, b=7 -> result=2 (with MULDIV_REM_EN); result=14 without it.
REQ-030 SHALL verify: op=01, a=1234, b=0 -> done 1 cycle after start, result=32'hFFFFFFFF; op=10 same operands -> result=1234.
REQ-031 SHALL verify: start op=01 a=50 b=5, assert reset low at cycle 10 for 2 cycles -> busy 0, done 0, result 0, no done pulse afterward; new start a=9 b=3 -> result=3.
REQ-032 SHALL verify: during busy, pulse start with a=1, b=1, op=00 -> ignored; original operation completes with its correct result at the original cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative unsigned multiply / divide unit.
//
// One radix-2 step per clock: shift-add for mul (low XLEN product bits),
// restoring division for divu/remu. Result is registered and held until the
// next operation completes.
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   reset   in   asynchronous reset, active low
//   start   in   request an operation (accepted only in IDLE or DONE)
//   op      in   2'b00 mul, 2'b01 divu, 2'b10 remu, 2'b11 treated as mul
//   a, b    in   operands, captured on the accepting edge
//   busy    out  iterating (MUL or DIV state)
//   done    out  one-cycle pulse, result valid
//   result  out  registered result
//
// Build option: define MULDIV_REM_EN to return the remainder for op 2'b10;
// without it op 2'b10 returns the quotient, same as divu.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] opa;   // mul: shifted multiplicand; div: dividend shifting into quotient
    logic [XLEN-1:0] opb;   // mul: shifted multiplier;   div: divisor
    logic [XLEN-1:0] acc;   // mul: product accumulator;  div: partial remainder
    logic [CNTW-1:0] cnt;
`ifdef MULDIV_REM_EN
    logic            rem_sel;
`endif

    logic            is_div;
    logic            last;
    logic [XLEN-1:0] mul_acc_nxt;
    logic [XLEN:0]   div_trial;
    logic            div_ok;
    logic [XLEN-1:0] div_rem_nxt;
    logic [XLEN-1:0] div_quo_nxt;
    logic [XLEN-1:0] div_res;
    logic [XLEN-1:0] dz_res;

    assign is_div      = (op == 2'b01) || (op == 2'b10);
    assign last        = (cnt == CNTW'(XLEN - 1));

    assign mul_acc_nxt = acc + (opb[0] ? opa : '0);

    // Restoring step: shift next dividend bit into the remainder, subtract
    // the divisor if it fits. The difference is always < 2^XLEN when it fits,
    // so a modulo-XLEN subtract is exact.
    assign div_trial   = {acc, opa[XLEN-1]};
    assign div_ok      = (div_trial >= {1'b0, opb});
    assign div_rem_nxt = div_ok ? (div_trial[XLEN-1:0] - opb) : div_trial[XLEN-1:0];
    assign div_quo_nxt = {opa[XLEN-2:0], div_ok};

`ifdef MULDIV_REM_EN
    assign div_res = rem_sel ? div_rem_nxt : div_quo_nxt;
    assign dz_res  = (op == 2'b10) ? a : '1;
`else
    assign div_res = div_quo_nxt;
    assign dz_res  = '1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            opa     <= '0;
            opb     <= '0;
            acc     <= '0;
            cnt     <= '0;
`ifdef MULDIV_REM_EN
            rem_sel <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        opa <= a;
                        opb <= b;
                        acc <= '0;
                        cnt <= '0;
`ifdef MULDIV_REM_EN
                        rem_sel <= (op == 2'b10);
`endif
                        if (is_div && (b == '0)) begin
                            // divide by zero completes on the accepting edge
                            result <= dz_res;
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            state <= is_div ? DIV : MUL;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                MUL: begin
                    acc <= mul_acc_nxt;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result <= mul_acc_nxt;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin // DIV
                    acc <= div_rem_nxt;
                    opa <= div_quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result <= div_res;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- scoreboard bench for muldiv_unit.
// Stimulus pushes expected {result, completion cycle} into a queue; a negedge
// monitor checks busy/done/result every cycle against the queue head.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    muldiv_unit #(.XLEN(XLEN), .CNTW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] res;
        int              due;
        string           name;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              failures = 0;
    logic [XLEN-1:0] held = '0;
    int              free_cyc = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic on the operation semantics.
    function automatic logic [XLEN-1:0] model(input logic [1:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        case (o)
            2'b01: return (y == '0) ? '1 : x / y;
`ifdef MULDIV_REM_EN
            2'b10: return (y == '0) ? x : x % y;
`else
            2'b10: return (y == '0) ? '1 : x / y;
`endif
            default: return x * y;
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (!reset) begin
            check("reset_busy", {31'b0, busy}, '0);
            check("reset_done", {31'b0, done}, '0);
            check("reset_result", result, '0);
            held = '0;
        end else begin
            exp_busy = (sb.size() > 0) && (sb[0].due > cyc);
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check($sformatf("%s_done", e.name), {31'b0, done}, 1);
                check($sformatf("%s_result", e.name), result, e.res);
                held = e.res;
            end else begin
                check("no_spurious_done", {31'b0, done}, '0);
                check("result_hold", result, held);
            end
        end
    end

    // Issue one operation as soon as the unit can accept it (DONE cycle or idle).
    task automatic issue(input string name, input logic [1:0] o, input logic [XLEN-1:0] x,
                         input logic [XLEN-1:0] y, input int gap);
        int lat;
        exp_t e;
        @(negedge clk);
        while (cyc < free_cyc) @(negedge clk);
        repeat (gap) @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = $urandom(); a = $urandom(); b = $urandom();
        lat = ((o == 2'b01 || o == 2'b10) && y == '0) ? 0 : XLEN;
        e.res = model(o, x, y);
        e.due = cyc + lat;
        e.name = name;
        sb.push_back(e);
        free_cyc = e.due;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lim;
        logic [XLEN-1:0] ra, rb;
        logic [1:0] ro;
        // reset state
        repeat (3) @(negedge clk);
        #2;
        check("init_busy", {31'b0, busy}, '0);
        check("init_result", result, '0);
        reset = 1'b1;

        issue("mul_7x6", 2'b00, 32'd7, 32'd6, 0);
        issue("mul_ffff_x2", 2'b00, 32'hFFFF_FFFF, 32'd2, 0);
        issue("divu_100_7_b2b", 2'b01, 32'd100, 32'd7, 0);   // accepted in DONE cycle
        issue("remu_100_7", 2'b10, 32'd100, 32'd7, 2);
        issue("divu_by0", 2'b01, 32'd1234, 32'd0, 1);
        issue("remu_by0", 2'b10, 32'd1234, 32'd0, 0);
        issue("mul_op11", 2'b11, 32'd12345, 32'd1000, 0);

        // start pulse while busy must be ignored
        issue("mul_ignore", 2'b00, 32'd123457, 32'd678, 1);
        repeat (5) @(negedge clk);
        op = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        // reset in the middle of a divide: no done afterwards
        issue("divu_aborted", 2'b01, 32'd50, 32'd5, 3);
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        free_cyc = 0;
        #1;
        check("abort_busy", {31'b0, busy}, '0);
        check("abort_done", {31'b0, done}, '0);
        check("abort_result", result, '0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        repeat (40) @(negedge clk);
        issue("divu_9_3", 2'b01, 32'd9, 32'd3, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom();
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 16));
                2: rb = ra;
                default: rb = $urandom();
            endcase
            if ($urandom_range(0, 1) == 0) ra = ra >> $urandom_range(0, 31);
            issue($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, $urandom_range(0, 2));
        end

        lim = cyc + 3 * XLEN;
        while (sb.size() > 0 && cyc < lim) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain outstanding=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
